vga_tim_ctrl: RTL and testbench

Sequencer for the horizontal and vertical VGA timing counters. Generates the pixel-rate tick from a programmable divider and drives the count enables and clean restart of both counters. Holds shadowed copies of the porch/sync/visible sizes that software can only change at a frame boundary. Provides graceful start/stop, pixel-valid qualification and line/frame event pulses. Sits between the APB register file and the two timing counter instances.

---
 rtl/vga_tim_ctrl_if.sv | 41 ++++
 rtl/vga_tim_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_tim_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_tim_ctrl_if.sv
// Bus between the VGA timing controller, its register file and the h/v timing counters.
// Software config and counter status flow in; shadowed config and counter controls flow out.
interface vga_tim_ctrl_if #(
   parameter int TB_WIDTH  = 8,
   parameter int VB_WIDTH  = 12,
   parameter int DIV_WIDTH = 8
);
   logic                 en_i;
   logic [DIV_WIDTH-1:0] div_i;
   logic                 cfg_upd_i;
   logic [TB_WIDTH-1:0]  hbp_i, hsn_i, hfp_i;
   logic [VB_WIDTH-1:0]  hvlen_i;
   logic [TB_WIDTH-1:0]  vbp_i, vsn_i, vfp_i;
   logic [VB_WIDTH-1:0]  vvlen_i;
   logic                 hend_i, vend_i, hvis_i, vvis_i;

   logic [TB_WIDTH-1:0]  hbp_o, hsn_o, hfp_o;
   logic [VB_WIDTH-1:0]  hvlen_o;
   logic [TB_WIDTH-1:0]  vbp_o, vsn_o, vfp_o;
   logic [VB_WIDTH-1:0]  vvlen_o;
   logic                 hcnt_en_o, vcnt_en_o, cnt_rst_n_o, pix_en_o;
   logic                 line_irq_o, frame_irq_o, upd_ack_o, busy_o;

   modport master (
      output en_i, div_i, cfg_upd_i,
      output hbp_i, hsn_i, hfp_i, hvlen_i, vbp_i, vsn_i, vfp_i, vvlen_i,
      output hend_i, vend_i, hvis_i, vvis_i,
      input  hbp_o, hsn_o, hfp_o, hvlen_o, vbp_o, vsn_o, vfp_o, vvlen_o,
      input  hcnt_en_o, vcnt_en_o, cnt_rst_n_o, pix_en_o,
      input  line_irq_o, frame_irq_o, upd_ack_o, busy_o
   );

   modport slave (
      input  en_i, div_i, cfg_upd_i,
      input  hbp_i, hsn_i, hfp_i, hvlen_i, vbp_i, vsn_i, vfp_i, vvlen_i,
      input  hend_i, vend_i, hvis_i, vvis_i,
      output hbp_o, hsn_o, hfp_o, hvlen_o, vbp_o, vsn_o, vfp_o, vvlen_o,
      output hcnt_en_o, vcnt_en_o, cnt_rst_n_o, pix_en_o,
      output line_irq_o, frame_irq_o, upd_ack_o, busy_o
   );
endinterface

// File: rtl/vga_tim_ctrl.sv
// VGA timing sequencer: pixel-tick divider, counter enables, frame-boundary config shadowing,
// graceful start/stop and line/frame event pulses.
module vga_tim_ctrl #(
   parameter int TB_WIDTH  = 8,
   parameter int VB_WIDTH  = 12,
   parameter int DIV_WIDTH = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   vga_tim_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_STOP_PEND} state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

   state_t               r_state;
   logic [DIV_WIDTH-1:0] r_div_cnt, r_div_shd;
   logic [TB_WIDTH-1:0]  r_hbp, r_hsn, r_hfp, r_vbp, r_vsn, r_vfp;
   logic [VB_WIDTH-1:0]  r_hvlen, r_vvlen;
   logic                 r_upd_pend, r_busy, r_cnt_rst_n;
   logic                 r_line_irq, r_frame_irq, r_upd_ack;

   logic w_active, w_tick, w_hcnt_en, w_vcnt_en, w_frame_end;
   logic w_upd_req, w_apply, w_load;

   assign w_active    = r_busy;
   assign w_tick      = (r_div_cnt == '0);
   assign w_hcnt_en   = w_active & w_tick;
   assign w_vcnt_en   = w_hcnt_en & bus.hend_i;
   assign w_frame_end = w_vcnt_en & bus.vend_i;

   // A request arriving on the very frame_end cycle is honoured on that boundary.
   assign w_upd_req = r_upd_pend | bus.cfg_upd_i;
   assign w_apply   = w_upd_req & ((r_state == ST_IDLE) | w_frame_end);
   assign w_load    = w_apply | (r_state == ST_START);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_div_cnt   <= '0;
         r_div_shd   <= '0;
         r_hbp       <= '0;
         r_hsn       <= '0;
         r_hfp       <= '0;
         r_hvlen     <= '0;
         r_vbp       <= '0;
         r_vsn       <= '0;
         r_vfp       <= '0;
         r_vvlen     <= '0;
         r_upd_pend  <= 1'b0;
         r_busy      <= 1'b0;
         r_cnt_rst_n <= 1'b0;
         r_line_irq  <= 1'b0;
         r_frame_irq <= 1'b0;
         r_upd_ack   <= 1'b0;
      end else begin
         r_line_irq  <= w_vcnt_en;
         r_frame_irq <= w_frame_end;
         r_upd_ack   <= w_apply;

         if (w_load) begin
            r_div_shd <= bus.div_i;
            r_hbp     <= bus.hbp_i;
            r_hsn     <= bus.hsn_i;
            r_hfp     <= bus.hfp_i;
            r_hvlen   <= bus.hvlen_i;
            r_vbp     <= bus.vbp_i;
            r_vsn     <= bus.vsn_i;
            r_vfp     <= bus.vfp_i;
            r_vvlen   <= bus.vvlen_i;
         end

         if (r_state == ST_START)
            r_upd_pend <= 1'b0;
         else
            r_upd_pend <= w_upd_req & ~w_apply;

         // Held at zero outside the running states so the first running cycle ticks.
         if (w_active)
            r_div_cnt <= w_tick ? r_div_shd : (r_div_cnt - DIV_ONE);
         else
            r_div_cnt <= '0;

         case (r_state)
            ST_IDLE: begin
               if (bus.en_i)
                  r_state <= ST_START;
            end
            ST_START: begin
               if (bus.en_i) begin
                  r_state     <= ST_RUN;
                  r_busy      <= 1'b1;
                  r_cnt_rst_n <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!bus.en_i)
                  r_state <= ST_STOP_PEND;
            end
            ST_STOP_PEND: begin
               if (bus.en_i) begin
                  r_state <= ST_RUN;
               end else if (w_frame_end) begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_cnt_rst_n <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_cnt_rst_n <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hbp_o       = r_hbp;
   assign bus.hsn_o       = r_hsn;
   assign bus.hfp_o       = r_hfp;
   assign bus.hvlen_o     = r_hvlen;
   assign bus.vbp_o       = r_vbp;
   assign bus.vsn_o       = r_vsn;
   assign bus.vfp_o       = r_vfp;
   assign bus.vvlen_o     = r_vvlen;
   assign bus.hcnt_en_o   = w_hcnt_en;
   assign bus.vcnt_en_o   = w_vcnt_en;
   assign bus.cnt_rst_n_o = r_cnt_rst_n;
   assign bus.pix_en_o    = w_hcnt_en & bus.hvis_i & bus.vvis_i;
   assign bus.line_irq_o  = r_line_irq;
   assign bus.frame_irq_o = r_frame_irq;
   assign bus.upd_ack_o   = r_upd_ack;
   assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_vga_tim_ctrl.sv
// Directed bench for vga_tim_ctrl with a behavioural model of the h/v timing counters.
module tb_vga_tim_ctrl;
   localparam int TBW = 8;
   localparam int VBW = 12;
   localparam int DVW = 8;

   logic clk_i = 1'b0;
   logic rst_n_i;
   always #5 clk_i = ~clk_i;

   vga_tim_ctrl_if #(.TB_WIDTH(TBW), .VB_WIDTH(VBW), .DIV_WIDTH(DVW)) bus ();

   vga_tim_ctrl #(.TB_WIDTH(TBW), .VB_WIDTH(VBW), .DIV_WIDTH(DVW)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus.slave)
   );

   // Counter model: each line is bp, visible (vlen+1), fp, sync; end flag on the last sync tick.
   int hc = 0, vc = 0, htot, vtot, hvs, vvs;
   always_comb begin
      htot = int'(bus.hbp_o) + int'(bus.hsn_o) + int'(bus.hfp_o) + int'(bus.hvlen_o) + 1;
      vtot = int'(bus.vbp_o) + int'(bus.vsn_o) + int'(bus.vfp_o) + int'(bus.vvlen_o) + 1;
      hvs  = int'(bus.hbp_o);
      vvs  = int'(bus.vbp_o);
   end
   assign bus.hend_i = (hc >= htot - 1);
   assign bus.vend_i = (vc >= vtot - 1);
   assign bus.hvis_i = (hc >= hvs) && (hc < hvs + int'(bus.hvlen_o) + 1);
   assign bus.vvis_i = (vc >= vvs) && (vc < vvs + int'(bus.vvlen_o) + 1);

   always @(posedge clk_i) begin
      if (!bus.cnt_rst_n_o) begin
         hc <= 0;
         vc <= 0;
      end else if (bus.hcnt_en_o) begin
         if (hc >= htot - 1) begin
            hc <= 0;
            vc <= (vc >= vtot - 1) ? 0 : vc + 1;
         end else begin
            hc <= hc + 1;
         end
      end
   end

   // Pulse monitor: irqs follow their enables by one cycle unless reset was sampled.
   logic p_v = 1'b0, p_fe = 1'b0, p_rst = 1'b0;
   int   mon_err = 0;
   always @(posedge clk_i) begin
      p_v   <= bus.vcnt_en_o;
      p_fe  <= bus.vcnt_en_o & bus.vend_i;
      p_rst <= rst_n_i;
   end
   always @(negedge clk_i) begin
      if (bus.line_irq_o !== (p_v & p_rst)) mon_err++;
      if (bus.frame_irq_o !== (p_fe & p_rst)) mon_err++;
      if (bus.vcnt_en_o !== (bus.hcnt_en_o & bus.hend_i)) mon_err++;
      if (bus.hcnt_en_o && !bus.busy_o) mon_err++;
   end

   typedef struct {
      int div;
      int hbp, hsn, hfp, hvlen;
      int vbp, vsn, vfp, vvlen;
      int first_fi, period, pix, lines, ticks;
   } vec_t;

   vec_t vecs[4];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic vec_t mk(int dv, int hb, int hs, int hf, int hl, int vb, int vs, int vf,
                               int vl, int ff, int pe, int px, int ln, int tk);
      vec_t v;
      v.div = dv; v.hbp = hb; v.hsn = hs; v.hfp = hf; v.hvlen = hl;
      v.vbp = vb; v.vsn = vs; v.vfp = vf; v.vvlen = vl;
      v.first_fi = ff; v.period = pe; v.pix = px; v.lines = ln; v.ticks = tk;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic apply_cfg(input vec_t v);
      bus.div_i   = DVW'(v.div);
      bus.hbp_i   = TBW'(v.hbp);
      bus.hsn_i   = TBW'(v.hsn);
      bus.hfp_i   = TBW'(v.hfp);
      bus.hvlen_i = VBW'(v.hvlen);
      bus.vbp_i   = TBW'(v.vbp);
      bus.vsn_i   = TBW'(v.vsn);
      bus.vfp_i   = TBW'(v.vfp);
      bus.vvlen_i = VBW'(v.vvlen);
   endtask

   task automatic to_fi(output int n, output int acks);
      n = 0;
      acks = 0;
      do begin
         step();
         n++;
         acks += int'(bus.upd_ack_o);
      end while (!bus.frame_irq_o && n < 3000);
   endtask

   // From IDLE: enable, check START/first RUN cycle, then time the first two frames.
   task automatic measure(input int i);
      int c, per, pix, lines, ticks;
      apply_cfg(vecs[i]);
      bus.en_i = 1'b1;
      step();
      chk("start_busy", int'(bus.busy_o), 0);
      chk("start_cnt_rst_n", int'(bus.cnt_rst_n_o), 0);
      step();
      chk("run_hcnt_en", int'(bus.hcnt_en_o), 1);
      chk("run_cnt_rst_n", int'(bus.cnt_rst_n_o), 1);
      chk("run_hvlen_o", int'(bus.hvlen_o), vecs[i].hvlen);
      chk("run_vbp_o", int'(bus.vbp_o), vecs[i].vbp);
      c = 0;
      do begin
         step();
         c++;
      end while (!bus.frame_irq_o && c < 3000);
      chk("first_frame_irq", c, vecs[i].first_fi);
      per = 0; pix = 0; lines = 0; ticks = 0;
      do begin
         pix   += int'(bus.pix_en_o);
         lines += int'(bus.line_irq_o);
         ticks += int'(bus.hcnt_en_o);
         step();
         per++;
      end while (!bus.frame_irq_o && per < 3000);
      chk("frame_period", per, vecs[i].period);
      chk("pix_per_frame", pix, vecs[i].pix);
      chk("lines_per_frame", lines, vecs[i].lines);
      chk("ticks_per_frame", ticks, vecs[i].ticks);
      $display("vec %0d: div=%0d first_irq=%0d period=%0d pix=%0d lines=%0d ticks=%0d",
               i, vecs[i].div, c, per, pix, lines, ticks);
   endtask

   initial begin
      int n, acks, bad;
      vecs[0] = mk(0, 2, 1, 2, 8, 1, 1, 1, 4, 112, 112, 45, 8, 112);
      vecs[1] = mk(3, 2, 1, 2, 8, 1, 1, 1, 4, 445, 448, 45, 8, 112);
      vecs[2] = mk(1, 1, 1, 1, 3, 2, 1, 1, 2,  97,  98, 12, 7,  49);
      vecs[3] = mk(2, 3, 2, 1, 1, 0, 1, 0, 1,  70,  72,  4, 3,  24);

      rst_n_i = 1'b0;
      bus.en_i = 1'b0;
      bus.cfg_upd_i = 1'b0;
      apply_cfg(vecs[0]);

      for (int i = 0; i < 4; i++) begin
         rst_n_i  = 1'b0;
         bus.en_i = 1'b0;
         apply_cfg(vecs[i]);
         step();
         step();
         chk("rst_busy", int'(bus.busy_o), 0);
         chk("rst_cnt_rst_n", int'(bus.cnt_rst_n_o), 0);
         chk("rst_hvlen_o", int'(bus.hvlen_o), 0);
         chk("rst_hcnt_en", int'(bus.hcnt_en_o), 0);
         rst_n_i = 1'b1;
         step();
         step();
         chk("idle_hbp_o", int'(bus.hbp_o), 0);
         chk("idle_busy", int'(bus.busy_o), 0);
         measure(i);
      end

      // Restart with the base config, then update hvlen mid-frame.
      rst_n_i  = 1'b0;
      bus.en_i = 1'b0;
      step();
      rst_n_i = 1'b1;
      step();
      measure(0);
      for (int k = 0; k < 20; k++) step();
      bus.hvlen_i   = VBW'(16);
      bus.cfg_upd_i = 1'b1;
      step();
      bus.cfg_upd_i = 1'b0;
      n = 0; bad = 0;
      while (!bus.frame_irq_o && n < 3000) begin
         if (bus.hvlen_o != VBW'(8)) bad++;
         step();
         n++;
      end
      chk("upd_hold_hvlen", bad, 0);
      chk("upd_hvlen_new", int'(bus.hvlen_o), 16);
      chk("upd_ack_pulse", int'(bus.upd_ack_o), 1);
      to_fi(n, acks);
      chk("upd_new_period", n, 176);
      chk("upd_ack_single", acks, 0);
      $display("cfg update mid-frame: new period=%0d", n);

      // Update request landing on the frame_end cycle itself.
      for (int k = 0; k < 175; k++) step();
      chk("fe_align", int'(bus.vcnt_en_o & bus.vend_i), 1);
      bus.hvlen_i   = VBW'(8);
      bus.cfg_upd_i = 1'b1;
      step();
      bus.cfg_upd_i = 1'b0;
      chk("fe_upd_irq", int'(bus.frame_irq_o), 1);
      chk("fe_upd_ack", int'(bus.upd_ack_o), 1);
      chk("fe_upd_hvlen", int'(bus.hvlen_o), 8);
      $display("cfg update on frame_end: hvlen_o=%0d", bus.hvlen_o);

      // Two requests in one frame produce one ack.
      for (int k = 0; k < 10; k++) step();
      bus.hbp_i     = TBW'(3);
      bus.cfg_upd_i = 1'b1;
      step();
      bus.cfg_upd_i = 1'b0;
      for (int k = 0; k < 5; k++) step();
      bus.cfg_upd_i = 1'b1;
      step();
      bus.cfg_upd_i = 1'b0;
      to_fi(n, acks);
      chk("dbl_upd_acks", acks, 1);
      chk("dbl_upd_hbp", int'(bus.hbp_o), 3);
      to_fi(n, acks);
      chk("dbl_upd_next_acks", acks, 0);
      chk("dbl_upd_period", n, 120);
      $display("double update: acks next frame=%0d period=%0d", acks, n);

      // Graceful stop mid-frame.
      for (int k = 0; k < 30; k++) step();
      bus.en_i = 1'b0;
      n = 0; bad = 0;
      while (!bus.frame_irq_o && n < 3000) begin
         if (!bus.busy_o) bad++;
         step();
         n++;
      end
      chk("stop_busy_hold", bad, 0);
      chk("stop_len", n, 90);
      chk("stop_busy_off", int'(bus.busy_o), 0);
      chk("stop_cnt_rst_n", int'(bus.cnt_rst_n_o), 0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (bus.busy_o || bus.hcnt_en_o) bad++;
      end
      chk("idle_quiet", bad, 0);
      $display("stop: frame completed after %0d cycles", n);

      // Config update while idle.
      bus.vvlen_i   = VBW'(2);
      bus.cfg_upd_i = 1'b1;
      step();
      bus.cfg_upd_i = 1'b0;
      chk("idle_upd_vvlen", int'(bus.vvlen_o), 2);
      chk("idle_upd_ack", int'(bus.upd_ack_o), 1);
      step();
      chk("idle_upd_ack_end", int'(bus.upd_ack_o), 0);
      $display("idle update: vvlen_o=%0d", bus.vvlen_o);

      // Cancel a stop before frame_end: no gap in the pixel ticks.
      bus.vvlen_i = VBW'(4);
      bus.hbp_i   = TBW'(2);
      bus.en_i    = 1'b1;
      step();
      step();
      for (int k = 0; k < 40; k++) step();
      bus.en_i = 1'b0;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (!bus.hcnt_en_o || !bus.busy_o) bad++;
         step();
      end
      bus.en_i = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (!bus.hcnt_en_o || !bus.busy_o) bad++;
         step();
      end
      chk("cancel_stop_gaps", bad, 0);
      $display("stop cancelled: gaps=%0d", bad);

      // Reset on a line-end cycle: no irq escapes, then restart reproduces the base timing.
      to_fi(n, acks);
      for (int k = 0; k < 13; k++) step();
      chk("pre_rst_vcnt_en", int'(bus.vcnt_en_o), 1);
      rst_n_i = 1'b0;
      step();
      rst_n_i = 1'b1;
      chk("mrst_line_irq", int'(bus.line_irq_o), 0);
      chk("mrst_frame_irq", int'(bus.frame_irq_o), 0);
      chk("mrst_busy", int'(bus.busy_o), 0);
      chk("mrst_cnt_rst_n", int'(bus.cnt_rst_n_o), 0);
      chk("mrst_hcnt_en", int'(bus.hcnt_en_o), 0);
      chk("mrst_upd_ack", int'(bus.upd_ack_o), 0);
      chk("mrst_hvlen_o", int'(bus.hvlen_o), 0);
      $display("mid-line reset: outputs cleared");
      measure(0);

      chk("pulse_monitor", mon_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
